// File: rtl/vga_pkg.sv
// Shared VGA constants: visible raster size, sync idle level, default colour depth
// and the compositor's pixel latency.
package vga_pkg;

    localparam int   H_VISIBLE     = 640;
    localparam int   V_VISIBLE     = 480;
    localparam logic SYNC_IDLE     = 1'b1;
    localparam int   RGB_W_DEFAULT = 3;
    localparam int   MIXER_LAT     = 2;

endpackage

// File: rtl/sprite_layer_mixer_if.sv
// Pixel-stream bundle between VGA timing / sprite generators (master) and the
// layer compositor (slave).
interface sprite_layer_mixer_if #(
    parameter int LAYER_COUNT = 8,
    parameter int RGB_W       = vga_pkg::RGB_W_DEFAULT,
    parameter int IDX_W       = $clog2(LAYER_COUNT)
);

    logic                         frame_start;
    logic                         video_on;
    logic                         hsync_in;
    logic                         vsync_in;
    logic [LAYER_COUNT-1:0]       layer_valid;
    logic [LAYER_COUNT-1:0]       layer_active;
    logic [LAYER_COUNT*RGB_W-1:0] layer_rgb;
    logic [RGB_W-1:0]             bg_rgb;

    logic [RGB_W-1:0]             rgb_out;
    logic                         hsync_out;
    logic                         vsync_out;
    logic                         video_on_out;
    logic                         hit_any;
    logic [IDX_W-1:0]             hit_layer;
    logic [LAYER_COUNT-1:0]       collision;
    logic                         collision_valid;

    modport master (
        output frame_start, video_on, hsync_in, vsync_in,
               layer_valid, layer_active, layer_rgb, bg_rgb,
        input  rgb_out, hsync_out, vsync_out, video_on_out,
               hit_any, hit_layer, collision, collision_valid
    );

    modport slave (
        input  frame_start, video_on, hsync_in, vsync_in,
               layer_valid, layer_active, layer_rgb, bg_rgb,
        output rgb_out, hsync_out, vsync_out, video_on_out,
               hit_any, hit_layer, collision, collision_valid
    );

endinterface

// File: rtl/sprite_layer_mixer_prio_encoder.sv
// Lowest-index-wins priority encoder; also used for bullet slot allocation.
module prio_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |req;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_layer_mixer.sv
// Two-stage sprite compositor: fixed-priority layer merge over background, delayed syncs.
// Define MIXER_COLLISION_EN to build the per-frame layer overlap accumulator.
module sprite_layer_mixer
    import vga_pkg::*;
#(
    parameter int LAYER_COUNT = 8,
    parameter int RGB_W       = RGB_W_DEFAULT,
    parameter int IDX_W       = $clog2(LAYER_COUNT)
) (
    input logic                 clk25,
    input logic                 reset_n,
    sprite_layer_mixer_if.slave bus
);

    logic [LAYER_COUNT-1:0] draw;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_any;
    logic [RGB_W-1:0]       win_rgb;

    assign draw = bus.layer_valid & bus.layer_active;

    prio_encoder #(
        .WIDTH (LAYER_COUNT),
        .IDX_W (IDX_W)
    ) u_prio (
        .req (draw),
        .idx (win_idx),
        .any (win_any)
    );

    assign win_rgb = win_any ? bus.layer_rgb[int'(win_idx) * RGB_W +: RGB_W] : bus.bg_rgb;

    // Stage 1: winner selection registered.
    logic [IDX_W-1:0] idx_p1;
    logic             any_p1;
    logic [RGB_W-1:0] rgb_p1;
    logic             video_on_p1;
    logic             hsync_p1;
    logic             vsync_p1;

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            idx_p1      <= '0;
            any_p1      <= 1'b0;
            rgb_p1      <= '0;
            video_on_p1 <= 1'b0;
            hsync_p1    <= SYNC_IDLE;
            vsync_p1    <= SYNC_IDLE;
        end else begin
            idx_p1      <= win_idx;
            any_p1      <= win_any;
            rgb_p1      <= win_rgb;
            video_on_p1 <= bus.video_on;
            hsync_p1    <= bus.hsync_in;
            vsync_p1    <= bus.vsync_in;
        end
    end

    // Stage 2: blanking applied, outputs registered.
    logic [RGB_W-1:0] rgb_p2;
    logic             hit_any_p2;
    logic [IDX_W-1:0] hit_layer_p2;
    logic             video_on_p2;
    logic             hsync_p2;
    logic             vsync_p2;

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            rgb_p2       <= '0;
            hit_any_p2   <= 1'b0;
            hit_layer_p2 <= '0;
            video_on_p2  <= 1'b0;
            hsync_p2     <= SYNC_IDLE;
            vsync_p2     <= SYNC_IDLE;
        end else begin
            rgb_p2       <= video_on_p1 ? rgb_p1 : '0;
            hit_any_p2   <= video_on_p1 & any_p1;
            hit_layer_p2 <= (video_on_p1 & any_p1) ? idx_p1 : '0;
            video_on_p2  <= video_on_p1;
            hsync_p2     <= hsync_p1;
            vsync_p2     <= vsync_p1;
        end
    end

    assign bus.rgb_out      = rgb_p2;
    assign bus.hit_any      = hit_any_p2;
    assign bus.hit_layer    = hit_layer_p2;
    assign bus.video_on_out = video_on_p2;
    assign bus.hsync_out    = hsync_p2;
    assign bus.vsync_out    = vsync_p2;

`ifdef MIXER_COLLISION_EN
    logic [LAYER_COUNT-1:0] draw_p1;
    logic                   frame_start_p1;
    logic [LAYER_COUNT-1:0] ov;
    logic [LAYER_COUNT-1:0] acc;
    logic [LAYER_COUNT-1:0] collision_p2;
    logic                   collision_vld_p2;

    // Two or more bits set is equivalent to popcount >= 2: clearing the lowest set bit leaves some.
    function automatic logic multi_hot(input logic [LAYER_COUNT-1:0] v);
        return (v & (v - LAYER_COUNT'(1))) != '0;
    endfunction

    assign ov = draw_p1 & {LAYER_COUNT{video_on_p1 & multi_hot(draw_p1)}};

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            draw_p1          <= '0;
            frame_start_p1   <= 1'b0;
            acc              <= '0;
            collision_p2     <= '0;
            collision_vld_p2 <= 1'b0;
        end else begin
            draw_p1        <= draw;
            frame_start_p1 <= bus.frame_start;
            if (frame_start_p1) begin
                // Pixel (0,0) opens the new frame, so its overlap seeds the fresh accumulator.
                collision_p2     <= acc;
                acc              <= ov;
                collision_vld_p2 <= 1'b1;
            end else begin
                acc              <= acc | ov;
                collision_vld_p2 <= 1'b0;
            end
        end
    end

    assign bus.collision       = collision_p2;
    assign bus.collision_valid = collision_vld_p2;
`else
    assign bus.collision       = '0;
    assign bus.collision_valid = 1'b0;
`endif

endmodule

// File: doc/sprite_layer_mixer.md
# sprite_layer_mixer

Parametrised, pipelined sprite compositor between the VGA controller and the colour output pins. Merges LAYER_COUNT sprite layers (player, bullets, enemies, HUD) by fixed index priority over a background colour, delays sync and blanking to match, and reports the winning layer per pixel. Optionally accumulates per-layer overlap flags across a frame and publishes them at the next frame start for gameplay hit logic.

## Interface
Parameters:
- LAYER_COUNT, 8: number of sprite layers; layer 0 has highest priority; legal 2..32.
- RGB_W, 3: colour bits per pixel (3 = 1 bit per channel; 12 = 4 bits per channel).
- IDX_W, $clog2(LAYER_COUNT): width of winning-layer index.

Ports:
- clk25  in  1  pixel clock, 25 MHz; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse coincident with pixel (0,0).
- video_on  in  1  pixel is inside the visible area.
- hsync_in, vsync_in  in  1  raw syncs from the VGA controller.
- layer_valid  in  LAYER_COUNT  sprite opaque at current pixel.
- layer_active  in  LAYER_COUNT  layer enable mask (bullet active, enemy alive).
- layer_rgb  in  LAYER_COUNT*RGB_W  layer i colour at [i*RGB_W +: RGB_W].
- bg_rgb  in  RGB_W  colour when no layer draws.
- rgb_out  out  RGB_W  composited pixel, zero when blanked.
- hsync_out, vsync_out, video_on_out  out  1  inputs delayed by pipeline latency.
- hit_any  out  1  some layer drew this output pixel.
- hit_layer  out  IDX_W  index of winning layer; 0 when hit_any=0.
- collision  out  LAYER_COUNT  per-layer overlap flags of the previous frame.
- collision_valid  out  1  one-cycle pulse when collision updates.

## Operation
- draw[i] = layer_valid[i] & layer_active[i].
- Stage 1 (registered): draw vector, first-set index of draw (lowest index wins), any = |draw, selected colour (winner's layer_rgb, else bg_rgb), video_on, syncs, frame_start.
- Stage 2 (registered): rgb_out = stage-1 video_on ? colour : 0; hit_any/hit_layer forced 0 when stage-1 video_on=0; syncs and video_on passed through.
- Overlap term per pixel: ov[i] = draw1[i] & video_on1 & (popcount(draw1) >= 2), using stage-1 registers.
- Accumulator acc[i] ORs ov[i] every cycle.
- When stage-1 frame_start is high: collision <= acc; acc <= ov (pixel (0,0) belongs to the new frame); collision_valid=1 for that cycle.
- Overlap with a layer whose layer_active=0 is not a collision.

## Timing
- Latency: inputs at cycle N appear on all pixel outputs at N+2; throughput one pixel per cycle, no stalls.
- collision/collision_valid update in cycle N+2 for frame_start at N.
- Reset (reset_n=0 at an edge): rgb_out=0, hit_any=0, hit_layer=0, video_on_out=0, hsync_out=1, vsync_out=1, collision=0, collision_valid=0, acc=0, all pipeline registers cleared (syncs to 1). Outputs valid again 2 cycles after release.
- Reset mid-frame discards the accumulator; the first collision_valid after reset follows the first frame_start and reports only pixels seen since release.
- frame_start asserted on consecutive cycles: each pulse publishes and restarts; no merging.
- All layers drawing simultaneously: layer 0 wins; every drawing layer flagged.

## Configuration
- MIXER_COLLISION_EN defined: accumulator, overlap logic, collision and collision_valid as above.
- Undefined: no accumulator or popcount built; collision tied to 0, collision_valid tied to 0; compositing and latency unchanged.

## Structure
- Shared package vga_pkg: H/V visible sizes (640, 480), sync idle level (1), default RGB_W, mixer latency constant MIXER_LAT = 2.
- One sub-module: prio_encoder (parameter WIDTH; outputs first-set index and any); reused by bullet slot allocation.

## Test plan
- Reset: hold reset_n=0 3 cycles with random inputs -> rgb_out=0, hsync_out=vsync_out=1, collision=0 throughout, 2 cycles after release outputs track inputs.
- Priority: layers 2 and 5 drawing, colours 3'b100/3'b010, video_on=1 -> 2 cycles later rgb_out=3'b100, hit_layer=2, hit_any=1.
- Mask/background: layer_valid=8'hFF, layer_active=0, bg_rgb=3'b001 -> rgb_out=3'b001, hit_any=0; same with video_on=0 -> rgb_out=0.
- Latency/sync: toggle hsync_in at cycle 10 -> hsync_out toggles at cycle 12; video_on_out likewise.
- Collision (EN): layers 0 and 3 overlap at one visible pixel in frame 1, frame_start at frame 2 -> collision=8'b00001001, collision_valid one cycle; frame 2 clean -> next publish collision=0.
- Collision edge (EN): overlap only at pixel (0,0) with frame_start -> reported in the following publish, not the current one; overlap with video_on=0 -> never reported.
